// File: rtl/game_flow_fsm.sv
// Battleship game sequencer: idle, placement, alternating turns with timeout,
// board lookup handshake, hit tallies and winner declaration.
module game_flow_fsm #(
  parameter int SHIP_CELLS   = 17,
  parameter int COORD_W      = 4,
  parameter int TURN_TIMEOUT = 1000,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               restart_pulse,
  input  logic               place_done_p1,
  input  logic               place_done_p2,
  input  logic               shot_valid,
  input  logic [COORD_W-1:0] shot_x,
  input  logic [COORD_W-1:0] shot_y,
  output logic               shot_ready,
  output logic               query_valid,
  output logic               query_player,
  output logic [COORD_W-1:0] query_x,
  output logic [COORD_W-1:0] query_y,
  input  logic               resp_valid,
  input  logic               resp_hit,
  output logic               idle_state,
  output logic               cur_player,
  output logic [4:0]         hits_p1,
  output logic [4:0]         hits_p2,
  output logic               winner_valid,
  output logic               winner,
  output logic               timeout_evt
);

  typedef enum logic [2:0] {
    IDLE,
    PLACE,
    TURN,
    QUERY,
    WAIT_RESP,
    DONE
  } state_t;

  localparam logic [4:0] SHIP_MAX = 5'(SHIP_CELLS);

  state_t             state_q, state_d;
  logic               cur_q, cur_d;
  logic [4:0]         hits1_q, hits1_d;
  logic [4:0]         hits2_q, hits2_d;
  logic [COORD_W-1:0] qx_q, qx_d;
  logic [COORD_W-1:0] qy_q, qy_d;
  logic               qp_q, qp_d;
  logic               win_q, win_d;
  logic               idle_q, idle_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         hit_next;
  logic               tmo;

  // Hit tallies stop at the win threshold instead of wrapping.
  function automatic logic [4:0] sat_inc(input logic [4:0] h);
    return (h >= SHIP_MAX) ? h : h + 5'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    hits1_d     = hits1_q;
    hits2_d     = hits2_q;
    qx_d        = qx_q;
    qy_d        = qy_q;
    qp_d        = qp_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    shot_ready  = 1'b0;
    query_valid = 1'b0;
    timeout_evt = 1'b0;
    hit_next    = sat_inc(cur_q ? hits2_q : hits1_q);
    tmo         = (TURN_TIMEOUT != 0) && (cnt_q == CNT_W'(TURN_TIMEOUT - 1));

    unique case (state_q)
      IDLE, DONE: begin
        if (restart_pulse) begin
          state_d = PLACE;
          hits1_d = '0;
          hits2_d = '0;
          cur_d   = 1'b0;
        end
      end
      PLACE: begin
        if (place_done_p1 && place_done_p2) begin
          state_d = TURN;
          cur_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      TURN: begin
        shot_ready = 1'b1;
        // An accepted shot takes precedence over a timeout on the same cycle.
        if (shot_valid) begin
          state_d = QUERY;
          qx_d    = shot_x;
          qy_d    = shot_y;
          qp_d    = ~cur_q;
        end else if (tmo) begin
          timeout_evt = 1'b1;
          cur_d       = ~cur_q;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      QUERY: begin
        query_valid = 1'b1;
        state_d     = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (resp_valid) begin
          if (resp_hit) begin
            if (cur_q) hits2_d = hit_next;
            else       hits1_d = hit_next;
          end
          if (resp_hit && (hit_next == SHIP_MAX)) begin
            state_d = DONE;
            win_d   = cur_q;
          end else begin
            state_d = TURN;
            cur_d   = ~cur_q;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    idle_d = (state_d == IDLE) || (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idle_q  <= 1'b1;
      cur_q   <= 1'b0;
      hits1_q <= '0;
      hits2_q <= '0;
      qx_q    <= '0;
      qy_q    <= '0;
      qp_q    <= 1'b0;
      win_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      cur_q   <= cur_d;
      hits1_q <= hits1_d;
      hits2_q <= hits2_d;
      qx_q    <= qx_d;
      qy_q    <= qy_d;
      qp_q    <= qp_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  assign idle_state   = idle_q;
  assign cur_player   = cur_q;
  assign hits_p1      = hits1_q;
  assign hits_p2      = hits2_q;
  assign query_x      = qx_q;
  assign query_y      = qy_q;
  assign query_player = qp_q;
  assign winner       = win_q;
  assign winner_valid = (state_q == DONE);

endmodule

// File: doc/game_flow_fsm.md
Name: game_flow_fsm

Overview:
Top-level battleship game sequencer: the consumer of restart_pulse and the producer of idle_state for the restart controller. It steps through idle, ship placement, alternating player turns, shot resolution against the board memory, and game-over. It tracks per-player hit counts and declares the winner. It sits between the input/debounce logic, the restart controller and the board/display logic.

Parameters:
SHIP_CELLS, 17, total ship cells per player; reaching this hit count wins the game.
COORD_W, 4, width of each shot coordinate.
TURN_TIMEOUT, 1000, cycles a player may idle in a turn before forfeiting it; 0 disables the timeout.
CNT_W, 32, width of the turn timeout counter.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
restart_pulse  input  1  one-cycle new-game request from the restart controller
place_done_p1  input  1  level; player 1 placement complete
place_done_p2  input  1  level; player 2 placement complete
shot_valid  input  1  shot request from the current player
shot_x  input  COORD_W  shot column
shot_y  input  COORD_W  shot row
shot_ready  output  1  FSM accepts a shot this cycle
query_valid  output  1  one-cycle board lookup strobe
query_player  output  1  board to query (opponent of shooter: 0=P1 board, 1=P2 board)
query_x  output  COORD_W  registered shot column
query_y  output  COORD_W  registered shot row
resp_valid  input  1  board lookup result valid
resp_hit  input  1  lookup result; 1=hit
idle_state  output  1  high in IDLE or DONE
cur_player  output  1  0=P1, 1=P2
hits_p1  output  5  hits scored by P1
hits_p2  output  5  hits scored by P2
winner_valid  output  1  high in DONE
winner  output  1  winning player; valid only while winner_valid is high
timeout_evt  output  1  one-cycle pulse when a turn is forfeited

Behaviour:
- Reset (rst_n low at a clk edge) forces state=IDLE, idle_state=1, and cur_player, hits, query_*, shot_ready, winner, winner_valid and timeout_evt all to 0. Reset has priority over every other input in any state.
- States: IDLE, PLACE, TURN, QUERY, WAIT_RESP, DONE.
- IDLE: restart_pulse -> PLACE; hits and cur_player cleared on the same edge.
- PLACE: place_done_p1 && place_done_p2 both high -> TURN with cur_player=0. restart_pulse is ignored.
- TURN: shot_ready=1 combinationally from state.
  - shot_valid && shot_ready: latch shot_x/shot_y into query_x/query_y and go to QUERY.
  - The timeout counter increments each TURN cycle and clears on entry to TURN.
  - Counter reaching TURN_TIMEOUT-1 without a shot: timeout_evt pulses for one cycle, cur_player toggles, TURN is re-entered, counter clears.
  - A shot accepted on the timeout cycle wins; no timeout fires.
- QUERY: query_valid=1 for exactly one cycle, query_player=~cur_player, then WAIT_RESP.
- WAIT_RESP: waits indefinitely for resp_valid; query_x/query_y/query_player stay stable. On resp_valid:
  - If resp_hit: increment the shooter's hit count.
  - If the incremented count == SHIP_CELLS: go to DONE with winner=cur_player.
  - Otherwise toggle cur_player and go to TURN.
- DONE: winner_valid=1 and winner is held. restart_pulse -> PLACE, clearing hits, winner_valid and cur_player.
- restart_pulse outside IDLE/DONE is ignored.
- resp_valid outside WAIT_RESP is ignored.
- shot_valid outside TURN is ignored; no shot is buffered.
- Hit counters saturate at SHIP_CELLS and never wrap.
- idle_state is registered and equals (state==IDLE || state==DONE).
- Shot-to-query latency: accept edge, then query_valid high in the next cycle.

Test Plan:
- Reset, restart_pulse, both place_done high -> idle_state 1→0, state TURN, cur_player=0, shot_ready=1.
- P1 shot (3,5), resp_hit=1 after 4 cycles -> query_valid pulses once with query_player=1, query_x=3, query_y=5; hits_p1=1; cur_player=1.
- TURN_TIMEOUT=10, no shot -> timeout_evt pulses at cycle 10, cur_player toggles, hits unchanged.
- SHIP_CELLS=2, P1 hits twice, P2 misses in between -> DONE, winner_valid=1, winner=0, idle_state=1; a later restart_pulse -> PLACE with hits_p1=hits_p2=0.
- restart_pulse during TURN and resp_valid during TURN -> no state change and no counter change; rst_n low in WAIT_RESP -> IDLE next edge with all outputs at reset values.
